data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//   Data-memory responder for the MIPS datapath: services the MemRead/MemWrite requests raised by the main
//   control decoder for lw/lhu/lbu/sw/sh/sb. Holds a word-wide RAM with configurable wait states, does
//   byte-lane select and sign/zero extension, and stalls the pipeline via a stall/done handshake.
//   Flags misaligned or illegal requests to the exception logic.
// PARAMETERS
//   ADDR_WIDTH   10  word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
//   WAIT_CYCLES  2   wait states before access completes; legal range 1..15
// PORTS
//   clk          in   1   single clock; all state updates on rising edge
//   rst          in   1   reset, asynchronous, active-high
//   mem_read     in   1   load request (MemRead control bit)
//   mem_write    in   1   store request (MemWrite control bit)
//   size         in   2   00 word, 01 half, 10 byte, 11 illegal
//   unsigned_ld  in   1   1 = zero-extend load (lbu/lhu); 0 = sign-extend
//   addr         in   32  byte address from ALU
//   wdata        in   32  store data; byte/half taken from low bits
//   rdata        out  32  load result (registered)
//   stall        out  1   hold pipeline; = (mem_read|mem_write) & ~done
//   done         out  1   one-cycle pulse: request completed this cycle
//   err          out  1   one-cycle pulse coincident with done: request rejected
// BEHAVIOUR
//   Reset (async): state=IDLE, counter=0, rdata=0, done=0, err=0. RAM contents are NOT reset.
//   FSM states IDLE, BUSY, DONE. req = mem_read|mem_write.
//   IDLE: no req -> IDLE. Legal req -> latch addr/wdata/size/unsigned_ld/op, counter=WAIT_CYCLES-1, ->BUSY.
//     Illegal req -> DONE with err=1, no RAM access, rdata=0. Illegal = size==11, or both mem_read and
//     mem_write, or word with addr[1:0]!=0, or half with addr[0]!=0.
//   BUSY: counter!=0 -> decrement, stay. counter==0 -> perform access at this edge, ->DONE.
//   DONE: done=1 (err as set) for exactly this cycle; always -> IDLE next edge, new req never accepted here.
//   Latency: legal request first seen in cycle T0 -> done in T0+WAIT_CYCLES+1; illegal -> done in T0+1.
//   Back-to-back requests: one IDLE cycle between done and acceptance of the next request.
//   Pipeline holds inputs stable while stall=1; block uses only latched copies after acceptance.
//   RAM index = addr[ADDR_WIDTH+1:2]; higher address bits ignored (aliasing wrap).
//   Little-endian lanes: byte n of word = bits [8n+7:8n]. sb writes lane addr[1:0]; sh writes lanes
//     {2*addr[1]+1, 2*addr[1]}; sw writes all four. Other lanes unchanged.
//   Loads: selected lane extended to 32 bits per unsigned_ld; word loads unextended. rdata updated only on
//     load completion (or cleared on err); stores leave rdata unchanged.
//   Store writes RAM only at BUSY->DONE edge; reset before that edge discards the store entirely.
//   Reset mid-operation: FSM to IDLE immediately; stall then follows req & ~done (done=0) so the pipeline
//     stays held and the request is re-accepted after reset release.
// TESTING (WAIT_CYCLES=2, ADDR_WIDTH=10)
//   sw 0xDEADBEEF @0x10 then lw @0x10 -> each stall=1 for 3 cycles, done in T0+3, rdata=0xDEADBEEF.
//   lb @0x11 -> 0xFFFFFFBE; lbu @0x11 -> 0x000000BE; lh @0x12 -> 0xFFFFDEAD; lhu @0x12 -> 0x0000DEAD.
//   sb 0xAA @0x13, sh 0x1234 @0x10, lw @0x10 -> 0xAAAD1234.
//   lw @0x12 / sh @0x11 / size=11 / read+write both high -> done+err at T0+1, rdata=0, RAM unchanged.
//   sw 0x55 @0x20, assert rst during BUSY -> done=0, err=0, rdata=0, word @0x20 keeps prior value.
//   sw 0x77 @0x1000 then lw @0x0 -> rdata=0x00000077 (address wrap).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MIPS datapath: word RAM with wait states, byte/half lane
// handling, sign/zero extension and a stall/done/err handshake toward the pipeline.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LA_W  = ADDR_WIDTH + 2;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Request copies; only meaningful after acceptance, so they carry no reset.
  logic [LA_W-1:0]   la_q, la_d;
  logic [31:0]       wd_q, wd_d;
  logic [1:0]        sz_q, sz_d;
  logic              uns_q, uns_d;
  logic              wr_q, wr_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic              req;
  logic              illegal;
  logic              access;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  // High address bits alias onto the RAM by design.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[31:LA_W];

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_WORD: r = w;
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_WORD: r = wd;
      SZ_HALF: begin
        if (ln[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: r[{ln, 3'b000} +: 8] = wd[7:0];
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic rd, input logic wr, input logic [1:0] sz,
                                      input logic [1:0] a_lo);
    logic bad;
    bad = (sz == SZ_ILL) || (rd && wr);
    if (sz == SZ_WORD && a_lo != 2'b00) bad = 1'b1;
    if (sz == SZ_HALF && a_lo[0])       bad = 1'b1;
    return bad;
  endfunction

  assign req      = mem_read | mem_write;
  assign illegal  = is_illegal(mem_read, mem_write, size, addr[1:0]);
  assign idx      = la_q[LA_W-1:2];
  assign lane     = la_q[1:0];
  assign cur_word = mem[idx];
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    la_d    = la_q;
    wd_d    = wd_q;
    sz_d    = sz_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            la_d    = addr[LA_W-1:0];
            wd_d    = wdata;
            sz_d    = size;
            uns_d   = unsigned_ld;
            wr_d    = mem_write;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!wr_q) rdata_d = load_ext(cur_word, sz_q, lane, uns_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    la_q  <= la_d;
    wd_q  <= wd_d;
    sz_q  <= sz_d;
    uns_q <= uns_d;
    wr_q  <= wr_d;
  end

  // The write fires only on the BUSY->DONE edge; an async reset before it kills the store.
  assign mem_we    = access && wr_q;
  assign mem_wdata = store_merge(cur_word, wd_q, sz_q, lane);

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= mem_wdata;
  end

  assign done  = (state_q == DONE);
  assign err   = done & err_q;
  assign rdata = rdata_q;
  assign stall = req & ~done;

endmodule
